// File: rtl/tsmm_pkg.sv
// tsmm_pkg: shared types and default sizes for the tall-skinny matmul sequencer
package tsmm_pkg;
  localparam int DEF_ADDR_W = 20;
  localparam int DEF_M_W = 16;
  localparam int DEF_NK_W = 8;
  localparam int DEF_MAX_OUT = 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} tsmm_state_e;
  typedef struct packed {
    logic first;
    logic last;
    logic fin;
  } tsmm_pos_t;
endpackage

// File: rtl/tsmm_addr_gen.sv
// tsmm_addr_gen: i/j/k loop counters (k innermost) with adder-only A/B/C address generation
module tsmm_addr_gen import tsmm_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int M_W = DEF_M_W,
  parameter int NK_W = DEF_NK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              adv,
  input  logic [M_W-1:0]    m,
  input  logic [NK_W-1:0]   n,
  input  logic [NK_W-1:0]   k,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic [ADDR_W-1:0] c_addr,
  output tsmm_pos_t         pos
);
  logic [M_W-1:0] i;
  logic [NK_W-1:0] j, kk;
  logic [ADDR_W-1:0] a_base;
  logic k_wrap, j_wrap;
  assign k_wrap = kk == k - NK_W'(1);
  assign j_wrap = j == n - NK_W'(1);
  assign pos = '{first: kk == '0, last: k_wrap, fin: k_wrap && j_wrap && i == m - M_W'(1)};
  // a_base tracks i*K; a_addr runs linearly through a row and rewinds to a_base per column
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {i, j, kk, a_base, a_addr, b_addr, c_addr} <= '0;
    else if (clear) {i, j, kk, a_base, a_addr, b_addr, c_addr} <= '0;
    else if (adv) begin
      kk <= k_wrap ? '0 : kk + NK_W'(1);
      j <= !k_wrap ? j : j_wrap ? '0 : j + NK_W'(1);
      i <= k_wrap && j_wrap ? i + M_W'(1) : i;
      a_base <= k_wrap && j_wrap ? a_base + ADDR_W'(k) : a_base;
      a_addr <= !k_wrap ? a_addr + ADDR_W'(1) : j_wrap ? a_base + ADDR_W'(k) : a_base;
      b_addr <= !k_wrap ? b_addr + ADDR_W'(n) : j_wrap ? '0 : ADDR_W'(j) + ADDR_W'(1);
      c_addr <= k_wrap ? c_addr + ADDR_W'(1) : c_addr;
    end
endmodule

// File: rtl/tsmm_sequencer.sv
// tsmm_sequencer: issues one A/B operand beat per cycle for C = A*B and bounds in-flight dot products
module tsmm_sequencer import tsmm_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int M_W = DEF_M_W,
  parameter int NK_W = DEF_NK_W,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [M_W-1:0]    cfg_m,
  input  logic [NK_W-1:0]   cfg_n,
  input  logic [NK_W-1:0]   cfg_k,
  output logic              busy,
  output logic              done,
  output logic              err_cfg,
  output logic              err_res,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [ADDR_W-1:0] op_a_addr,
  output logic [ADDR_W-1:0] op_b_addr,
  output logic              op_first,
  output logic              op_last,
  output logic [ADDR_W-1:0] op_c_addr,
  input  logic              res_valid
);
  localparam int OUT_W = $clog2(MAX_OUT) + 1;
  tsmm_state_e state, state_nx;
  tsmm_pos_t pos;
  logic [M_W-1:0] m_q;
  logic [NK_W-1:0] n_q, k_q;
  logic [OUT_W-1:0] outstanding;
  logic cfg_zero, err_cfg_q, launch, run, issue_last;
  assign cfg_zero = cfg_m == '0 || cfg_n == '0 || cfg_k == '0;
  assign launch = state == IDLE && start;
  assign run = state == RUN;
  // only a fresh dot product waits for a result slot; a started one always runs to its last beat
  assign op_valid = run && !(pos.first && outstanding == OUT_W'(MAX_OUT));
  assign op_first = run && pos.first;
  assign op_last = run && pos.last;
  assign issue_last = op_valid && op_ready && pos.last;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign err_cfg = done && err_cfg_q;
  tsmm_addr_gen #(.ADDR_W(ADDR_W), .M_W(M_W), .NK_W(NK_W)) u_addr (
    .clk(clk), .rst_n(rst_n), .clear(launch), .adv(op_valid && op_ready),
    .m(m_q), .n(n_q), .k(k_q),
    .a_addr(op_a_addr), .b_addr(op_b_addr), .c_addr(op_c_addr), .pos(pos)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = cfg_zero ? DONE : RUN;
      RUN: if (op_valid && op_ready && pos.fin) state_nx = DRAIN;
      DRAIN: if (outstanding == '0) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      {m_q, n_q, k_q, err_cfg_q, err_res, outstanding} <= '0;
    end else begin
      state <= state_nx;
      if (launch) {m_q, n_q, k_q, err_cfg_q} <= {cfg_m, cfg_n, cfg_k, cfg_zero};
      err_res <= !launch && (err_res || (res_valid && outstanding == '0));
      outstanding <= issue_last && !res_valid ? outstanding + OUT_W'(1)
                   : res_valid && !issue_last && outstanding != '0 ? outstanding - OUT_W'(1)
                   : outstanding;
    end
endmodule

// File: tb/tb_tsmm_sequencer.sv
// tb_tsmm_sequencer: directed scenarios for the matmul sequencer, including a MAX_OUT=2 instance
module tb_tsmm_sequencer;
  typedef struct {logic [19:0] a, b, c; logic f, l; int cyc;} beat_t;
  logic clk = 1'b0;
  logic rst_n, start, start2, op_ready, res_man, res_auto, auto_en, res_valid;
  logic [15:0] cfg_m;
  logic [7:0] cfg_n, cfg_k;
  logic busy, done, err_cfg, err_res, op_valid, op_first, op_last;
  logic [19:0] op_a_addr, op_b_addr, op_c_addr;
  logic busy2, done2, err_cfg2, err_res2, op_valid2, op_first2, op_last2;
  logic [19:0] op_a_addr2, op_b_addr2, op_c_addr2;
  logic [2:0] pipe;
  int cyc = 0, checks = 0, errors = 0, d2 = 0, stray = 0;
  beat_t beats[$];
  logic [19:0] b2[$];
  int done_cyc[$], res_cyc[$];
  logic done_err[$];

  assign res_valid = res_man | res_auto;
  always #5 clk = ~clk;

  tsmm_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
    .busy(busy), .done(done), .err_cfg(err_cfg), .err_res(err_res), .op_valid(op_valid),
    .op_ready(op_ready), .op_a_addr(op_a_addr), .op_b_addr(op_b_addr), .op_first(op_first),
    .op_last(op_last), .op_c_addr(op_c_addr), .res_valid(res_valid)
  );
  tsmm_sequencer #(.MAX_OUT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
    .busy(busy2), .done(done2), .err_cfg(err_cfg2), .err_res(err_res2), .op_valid(op_valid2),
    .op_ready(op_ready), .op_a_addr(op_a_addr2), .op_b_addr(op_b_addr2), .op_first(op_first2),
    .op_last(op_last2), .op_c_addr(op_c_addr2), .res_valid(res_valid)
  );

  always @(posedge clk) cyc++;

  // mid-cycle monitor; also returns each dot-product result 3 cycles after its last beat
  always @(negedge clk) begin
    if (op_valid && op_ready) beats.push_back('{op_a_addr, op_b_addr, op_c_addr, op_first, op_last, cyc});
    if (op_valid2 && op_ready) b2.push_back(op_a_addr2);
    if (done) begin
      done_cyc.push_back(cyc);
      done_err.push_back(err_cfg);
    end
    if (done2) d2++;
    if (err_cfg && !done) stray++;
    res_auto = auto_en && pipe[2];
    pipe = auto_en ? {pipe[1:0], op_valid && op_ready && op_last} : 3'b0;
    if (res_man | res_auto) res_cyc.push_back(cyc);
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  function automatic logic [61:0] exp_beat(int q, int n, int k);
    int kk = q % k, j = (q / k) % n, i = q / (k * n);
    return {20'(i * k + kk), 20'(kk * n + j), 20'(i * n + j), kk == 0, kk == k - 1};
  endfunction

  task automatic clear_logs();
    beats.delete();
    done_cyc.delete();
    done_err.delete();
    res_cyc.delete();
  endtask

  task automatic launch(input logic [15:0] m, input logic [7:0] n, input logic [7:0] k,
                        input logic two, output int c0);
    @(posedge clk); #1;
    cfg_m = m; cfg_n = n; cfg_k = k;
    if (two) start2 = 1'b1; else start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int t = 0; t < budget && done_cyc.size() == 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err_cfg, err_res, op_valid, op_first, op_last, op_a_addr, op_b_addr, op_c_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {busy, done, err_cfg, err_res, op_valid, op_first, op_last, op_a_addr, op_b_addr, op_c_addr});
    end
    checks++;
    if ({busy2, done2, op_valid2, op_first2, op_last2} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs2 got %b want 00000", {busy2, done2, op_valid2, op_first2, op_last2});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, op_valid, done} !== 3'b0) begin
      errors++;
      $display("FAIL idle_after_reset got %b want 000", {busy, op_valid, done});
    end
  endtask

  task automatic test_basic();
    int c0;
    clear_logs();
    op_ready = 1'b1; auto_en = 1'b1;
    launch(16'd3, 8'd2, 8'd4, 1'b0, c0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", busy); end
    wait_done(300);
    checks++;
    if (beats.size() != 24) begin errors++; $display("FAIL basic_beat_count got %0d want 24", beats.size()); end
    if (beats.size() == 24) begin
      for (int q = 0; q < 24; q++) begin
        checks++;
        if ({beats[q].a, beats[q].b, beats[q].c, beats[q].f, beats[q].l} !== exp_beat(q, 2, 4)) begin
          errors++;
          $display("FAIL basic_beat%0d got %h want %h", q, {beats[q].a, beats[q].b, beats[q].c, beats[q].f, beats[q].l}, exp_beat(q, 2, 4));
        end
      end
      checks++;
      if (beats[0].cyc != c0 + 1 || beats[23].cyc != c0 + 24) begin
        errors++;
        $display("FAIL basic_timing got %0d..%0d want %0d..%0d", beats[0].cyc - c0, beats[23].cyc - c0, 1, 24);
      end
      checks++;
      if ({beats[0].a, beats[0].b, beats[0].f} !== {20'd0, 20'd0, 1'b1}) begin
        errors++;
        $display("FAIL first_beat got a=%0d b=%0d f=%b want 0 0 1", beats[0].a, beats[0].b, beats[0].f);
      end
      checks++;
      if ({beats[3].a, beats[3].b, beats[3].c, beats[3].l} !== {20'd3, 20'd6, 20'd0, 1'b1}) begin
        errors++;
        $display("FAIL beat4 got a=%0d b=%0d c=%0d l=%b want 3 6 0 1", beats[3].a, beats[3].b, beats[3].c, beats[3].l);
      end
      checks++;
      if ({beats[23].a, beats[23].b, beats[23].c} !== {20'd11, 20'd7, 20'd5}) begin
        errors++;
        $display("FAIL final_beat got a=%0d b=%0d c=%0d want 11 7 5", beats[23].a, beats[23].b, beats[23].c);
      end
    end
    checks++;
    if (res_cyc.size() != 6 || done_cyc.size() != 1) begin
      errors++;
      $display("FAIL basic_counts got res=%0d done=%0d want 6 1", res_cyc.size(), done_cyc.size());
    end
    if (res_cyc.size() == 6 && done_cyc.size() == 1) begin
      checks++;
      if (done_cyc[0] < res_cyc[5] + 1 || done_cyc[0] > res_cyc[5] + 2 || done_err[0] !== 1'b0) begin
        errors++;
        $display("FAIL basic_done got +%0d err_cfg=%b want +1..+2 err_cfg=0", done_cyc[0] - res_cyc[5], done_err[0]);
      end
    end
    checks++;
    if ({busy, err_res} !== 2'b00) begin errors++; $display("FAIL basic_end got busy,err_res=%b want 00", {busy, err_res}); end
  endtask

  task automatic test_ready_toggle();
    int c0;
    logic [62:0] held;
    logic hold = 1'b0;
    clear_logs();
    op_ready = 1'b0; auto_en = 1'b1;
    launch(16'd3, 8'd2, 8'd4, 1'b0, c0);
    for (int t = 0; t < 300 && done_cyc.size() == 0; t++) begin
      @(negedge clk);
      if (hold) begin
        checks++;
        if ({op_valid, op_a_addr, op_b_addr, op_c_addr, op_first, op_last} !== held) begin
          errors++;
          $display("FAIL stall_stable cyc %0d got %h want %h", cyc, {op_valid, op_a_addr, op_b_addr, op_c_addr, op_first, op_last}, held);
        end
      end
      hold = op_valid && !op_ready;
      held = {op_valid, op_a_addr, op_b_addr, op_c_addr, op_first, op_last};
      @(posedge clk); #1;
      op_ready = (cyc - c0) % 2 == 0;
    end
    op_ready = 1'b1;
    wait_done(10);
    checks++;
    if (beats.size() != 24) begin errors++; $display("FAIL toggle_beat_count got %0d want 24", beats.size()); end
    if (beats.size() == 24) begin
      for (int q = 0; q < 24; q++) begin
        checks++;
        if ({beats[q].a, beats[q].b, beats[q].c, beats[q].f, beats[q].l} !== exp_beat(q, 2, 4)) begin
          errors++;
          $display("FAIL toggle_beat%0d got %h want %h", q, {beats[q].a, beats[q].b, beats[q].c, beats[q].f, beats[q].l}, exp_beat(q, 2, 4));
        end
      end
      checks++;
      if (beats[0].cyc != c0 + 2 || beats[23].cyc != c0 + 48) begin
        errors++;
        $display("FAIL toggle_window got %0d..%0d want 2..48", beats[0].cyc - c0, beats[23].cyc - c0);
      end
    end
    checks++;
    if (done_cyc.size() != 1) begin errors++; $display("FAIL toggle_done got %0d want 1", done_cyc.size()); end
  endtask

  task automatic test_idle_res();
    int c0;
    checks++;
    if (err_res !== 1'b0) begin errors++; $display("FAIL err_res_pre got %b want 0", err_res); end
    @(posedge clk); #1 res_man = 1'b1;
    @(posedge clk); #1 res_man = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({err_res, busy} !== 2'b10) begin errors++; $display("FAIL idle_res got err_res,busy=%b want 10", {err_res, busy}); end
    clear_logs();
    op_ready = 1'b1; auto_en = 1'b1;
    launch(16'd1, 8'd1, 8'd1, 1'b0, c0);
    checks++;
    if (err_res !== 1'b0) begin errors++; $display("FAIL err_res_clear got %b want 0", err_res); end
    wait_done(50);
    checks++;
    if (beats.size() != 1 || done_cyc.size() != 1 || err_res !== 1'b0) begin
      errors++;
      $display("FAIL idle_res_job got beats=%0d done=%0d err_res=%b want 1 1 0", beats.size(), done_cyc.size(), err_res);
    end
  endtask

  task automatic test_throttle();
    int c0;
    b2.delete(); d2 = 0;
    auto_en = 1'b0; op_ready = 1'b1;
    launch(16'd4, 8'd1, 8'd1, 1'b1, c0);
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (b2.size() != 2 || op_valid2 !== 1'b0 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL throttle_hold got beats=%0d valid=%b busy=%b want 2 0 1", b2.size(), op_valid2, busy2);
    end
    @(posedge clk); #1 res_man = 1'b1;
    @(posedge clk); #1 res_man = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (b2.size() != 3 || op_valid2 !== 1'b0) begin
      errors++;
      $display("FAIL throttle_release got beats=%0d valid=%b want 3 0", b2.size(), op_valid2);
    end
    repeat (3) begin
      @(posedge clk); #1 res_man = 1'b1;
      @(posedge clk); #1 res_man = 1'b0;
      repeat (3) @(posedge clk);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (b2.size() != 4 || d2 != 1 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL throttle_finish got beats=%0d done=%0d busy=%b want 4 1 0", b2.size(), d2, busy2);
    end
    if (b2.size() == 4) begin
      checks++;
      if ({b2[0], b2[1], b2[2], b2[3]} !== {20'd0, 20'd1, 20'd2, 20'd3}) begin
        errors++;
        $display("FAIL throttle_addr got %0d %0d %0d %0d want 0 1 2 3", b2[0], b2[1], b2[2], b2[3]);
      end
    end
  endtask

  task automatic test_cfg_zero();
    int c0;
    clear_logs();
    stray = 0;
    launch(16'd3, 8'd2, 8'd0, 1'b0, c0);
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (beats.size() != 0 || done_cyc.size() != 1) begin
      errors++;
      $display("FAIL cfg_zero_counts got beats=%0d done=%0d want 0 1", beats.size(), done_cyc.size());
    end
    if (done_cyc.size() == 1) begin
      checks++;
      if (done_err[0] !== 1'b1 || done_cyc[0] < c0 + 1 || done_cyc[0] > c0 + 2) begin
        errors++;
        $display("FAIL cfg_zero_done got err_cfg=%b at +%0d want 1 at +1..+2", done_err[0], done_cyc[0] - c0);
      end
    end
    checks++;
    if (stray != 0 || {busy, err_cfg} !== 2'b00) begin
      errors++;
      $display("FAIL cfg_zero_end got stray=%0d busy,err_cfg=%b want 0 00", stray, {busy, err_cfg});
    end
  endtask

  task automatic test_reset_mid();
    int c0, n = 0;
    clear_logs();
    op_ready = 1'b1; auto_en = 1'b1;
    launch(16'd3, 8'd2, 8'd4, 1'b0, c0);
    for (int t = 0; t < 100 && n < 10; t++) begin
      @(negedge clk);
      if (op_valid && op_ready) n++;
    end
    rst_n = 1'b0; auto_en = 1'b0;
    #1;
    checks++;
    if (n != 10 || {busy, done, op_valid, op_first, op_last, op_a_addr, op_b_addr, op_c_addr} !== '0) begin
      errors++;
      $display("FAIL reset_mid got n=%0d outs=%h want 10 0", n, {busy, done, op_valid, op_first, op_last, op_a_addr, op_b_addr, op_c_addr});
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    clear_logs();
    auto_en = 1'b1;
    launch(16'd1, 8'd1, 8'd2, 1'b0, c0);
    wait_done(50);
    checks++;
    if (beats.size() != 2 || done_cyc.size() != 1) begin
      errors++;
      $display("FAIL after_reset_counts got beats=%0d done=%0d want 2 1", beats.size(), done_cyc.size());
    end
    if (beats.size() == 2) begin
      for (int q = 0; q < 2; q++) begin
        checks++;
        if ({beats[q].a, beats[q].b, beats[q].c, beats[q].f, beats[q].l} !== exp_beat(q, 1, 2)) begin
          errors++;
          $display("FAIL after_reset_beat%0d got %h want %h", q, {beats[q].a, beats[q].b, beats[q].c, beats[q].f, beats[q].l}, exp_beat(q, 1, 2));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; op_ready = 1'b0; res_man = 1'b0; auto_en = 1'b0;
    cfg_m = '0; cfg_n = '0; cfg_k = '0;
    test_reset();
    test_basic();
    test_ready_toggle();
    test_idle_res();
    test_throttle();
    test_cfg_zero();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
